// File: rtl/load_store_aligner_pkg.sv
// Shared size encodings, FSM state type and helpers for load_store_aligner.
package lsu_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RWAIT = 2'b01,
    RESP  = 2'b10
  } state_e;

  // Encoding 2'b11 behaves exactly like a word access.
  function automatic logic [1:0] norm_size(input logic [1:0] size);
    return (size == 2'b11) ? SIZE_WORD : size;
  endfunction

endpackage

// File: rtl/load_store_aligner_if.sv
// Request/response handshake plus word-addressed memory port of the aligner.
interface load_store_aligner_if #(
  parameter int ADDR_W = 30
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/load_store_aligner_extend.sv
// load_extend: picks the addressed little-endian lane out of a word and
// sign- or zero-extends it to 32 bits; word accesses pass straight through.
module load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_signed,
  output logic [31:0] result
);

  logic signed [7:0]  byte_lane;
  logic signed [15:0] half_lane;

  always_comb begin
    byte_lane = word[{offset, 3'b000} +: 8];
    half_lane = offset[1] ? word[31:16] : word[15:0];
    result    = word;
    case (size)
      SIZE_BYTE: result = is_signed ? {{24{byte_lane[7]}}, byte_lane}
                                    : {24'b0, byte_lane};
      SIZE_HALF: result = is_signed ? {{16{half_lane[15]}}, half_lane}
                                    : {16'b0, half_lane};
      default:   result = word;
    endcase
  end

endmodule

// File: rtl/load_store_aligner.sv
// Byte-addressed load/store front end onto a word-addressed memory with
// read-modify-write sub-word stores. Optional MISALIGN_TRAP_EN traps misaligned accesses.
module load_store_aligner
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 30
) (
  input  logic                 clk,
  input  logic                 reset,
  load_store_aligner_if.slave  bus
);

  state_e            state, state_nxt;

  logic              lat_we;
  logic              lat_signed;
  logic [1:0]        lat_size;
  logic [1:0]        lat_off;
  logic [31:0]       lat_wdata;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic [1:0]        size_n;
  logic              misaligned;
  logic              accept;
  logic              store_word;
  logic [31:0]       ext_data;
  logic [31:0]       merged;
  logic              mem_en_c;
  logic              mem_we_c;
  logic [ADDR_W-1:0] mem_addr_c;
  logic [31:0]       mem_wdata_c;

  // Replace only the addressed byte or halfword lane of the read word.
  function automatic logic [31:0] merge_lane(input logic [31:0] old_word,
                                             input logic [31:0] st_data,
                                             input logic [1:0]  size,
                                             input logic [1:0]  off);
    logic [31:0] m;
    m = old_word;
    if (size == SIZE_BYTE) begin
      m[{off, 3'b000} +: 8] = st_data[7:0];
    end else if (off[1]) begin
      m[31:16] = st_data[15:0];
    end else begin
      m[15:0] = st_data[15:0];
    end
    return m;
  endfunction

  assign size_n     = norm_size(bus.req_size);
  assign accept     = (state == IDLE) && bus.req_valid && !reset;
  assign store_word = bus.req_we && (size_n == SIZE_WORD);

`ifdef MISALIGN_TRAP_EN
  assign misaligned = ((size_n == SIZE_HALF) && bus.req_addr[0]) ||
                      ((size_n == SIZE_WORD) && (bus.req_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  load_extend u_extend (
    .word      (bus.mem_rdata),
    .offset    (lat_off),
    .size      (lat_size),
    .is_signed (lat_signed),
    .result    (ext_data)
  );

  assign merged = merge_lane(bus.mem_rdata, lat_wdata, lat_size, lat_off);

  always_comb begin
    state_nxt   = state;
    mem_en_c    = 1'b0;
    mem_we_c    = 1'b0;
    mem_addr_c  = addr_q;
    mem_wdata_c = wdata_q;
    case (state)
      IDLE: begin
        if (accept) begin
          mem_addr_c = bus.req_addr[ADDR_W+1:2];
          if (misaligned) begin
            state_nxt = RESP;
          end else if (store_word) begin
            mem_en_c    = 1'b1;
            mem_we_c    = 1'b1;
            mem_wdata_c = bus.req_wdata;
            state_nxt   = RESP;
          end else begin
            mem_en_c  = 1'b1;
            state_nxt = RWAIT;
          end
        end
      end
      RWAIT: begin
        state_nxt = RESP;
        // A reset landing here must suppress the pending merge write.
        if (lat_we && !reset) begin
          mem_en_c    = 1'b1;
          mem_we_c    = 1'b1;
          mem_wdata_c = merged;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        addr_q <= bus.req_addr[ADDR_W+1:2];
        err_q  <= misaligned;
        if (misaligned || bus.req_we) begin
          rdata_q <= '0;
        end
        if (store_word && !misaligned) begin
          wdata_q <= bus.req_wdata;
        end
      end
      if (state == RWAIT) begin
        if (lat_we) begin
          wdata_q <= merged;
        end else begin
          rdata_q <= ext_data;
        end
      end
    end
  end

  // Request attributes only steer the datapath, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      lat_we     <= bus.req_we;
      lat_size   <= size_n;
      lat_signed <= bus.req_signed;
      lat_off    <= bus.req_addr[1:0];
      lat_wdata  <= bus.req_wdata;
    end
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign bus.mem_en     = mem_en_c;
  assign bus.mem_we     = mem_we_c;
  assign bus.mem_addr   = mem_addr_c;
  assign bus.mem_wdata  = mem_wdata_c;

endmodule

// File: tb/tb_load_store_aligner.sv
// Bench for load_store_aligner: byte-array reference model, response scoreboard,
// directed cases and randomized traffic. Honors MISALIGN_TRAP_EN.
module tb_load_store_aligner;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  load_store_aligner_if #(.ADDR_W(30)) ifc ();
  load_store_aligner #(.ADDR_W(30)) dut (.clk(clk), .reset(reset), .bus(ifc));

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  // Word-addressed memory behind the DUT (64 words, indexed by mem_addr[5:0]).
  logic [31:0] tbmem [64];
  logic        mem_load = 1'b0;

  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'h80FF_7F01;
    return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
  endfunction

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 64; i++) tbmem[i] <= init_word(i);
    end else if (ifc.mem_en) begin
      if (ifc.mem_we) tbmem[ifc.mem_addr[5:0]] <= ifc.mem_wdata;
      else            ifc.mem_rdata <= tbmem[ifc.mem_addr[5:0]];
    end
  end

  // Reference model: a plain byte array for the same 256-byte window.
  logic [7:0] mm [256];

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;
  exp_t q[$];

  logic [31:0] last_rdata = '0;
  logic        last_err = 1'b0;
  logic        obs_en, obs_we;
  logic [29:0] obs_addr;
  logic [31:0] obs_wdata;
  int          prev_acc = 0;
  int          prev_lat = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_exec(input logic we, input logic [1:0] size, input logic sgn,
                            input logic [31:0] addr, input logic [31:0] wd, input bit commit,
                            output logic [31:0] rd, output logic err, output int lat,
                            output bit access);
    int nbytes, a, base;
    logic [31:0] val;
    nbytes = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    a      = int'(addr[7:0]);
    base   = a - (a % nbytes);
    err    = TRAP && (a % nbytes != 0);
    rd     = '0;
    if (err) begin
      lat = 1; access = 1'b0;
    end else if (we) begin
      lat = (nbytes == 4) ? 1 : 2; access = 1'b1;
      if (commit) for (int k = 0; k < nbytes; k++) mm[base + k] = wd[8*k +: 8];
    end else begin
      lat = 2; access = 1'b1;
      val = '0;
      for (int k = 0; k < nbytes; k++) val = val | (32'(mm[base + k]) << (8 * k));
      if (sgn && nbytes < 4 && val[8*nbytes-1]) val = val | (32'hFFFF_FFFF << (8 * nbytes));
      rd = val;
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input bit expect_resp, input bit chain);
    exp_t e;
    bit   access;
    int   guard;
    ifc.req_we = we; ifc.req_size = size; ifc.req_signed = sgn;
    ifc.req_addr = addr; ifc.req_wdata = wd; ifc.req_valid = 1'b1;
    guard = 0;
    #1;
    while (!ifc.req_ready && guard < 10) begin
      if (ifc.resp_valid) check32("mem_en_in_resp", {31'b0, ifc.mem_en}, 32'd0);
      @(negedge clk); #1;
      guard++;
    end
    if (!ifc.req_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: req_ready=%b, required 1", ifc.req_ready);
      ifc.req_valid = 1'b0;
      return;
    end
    model_exec(we, size, sgn, addr, wd, expect_resp, e.rd, e.err, e.lat, access);
    e.acc = cyc;
    if (expect_resp) q.push_back(e);
    obs_en = ifc.mem_en; obs_we = ifc.mem_we; obs_addr = ifc.mem_addr; obs_wdata = ifc.mem_wdata;
    check32("mem_en_at_T", {31'b0, ifc.mem_en}, {31'b0, access});
    check32("mem_we_at_T", {31'b0, ifc.mem_we},
            {31'b0, access && we && (size[1] == 1'b1)});
    if (access) check32("mem_addr_at_T", {2'b0, ifc.mem_addr}, {2'b0, addr[31:2]});
    if (chain) check32("accept_gap", 32'(e.acc - prev_acc), 32'(prev_lat + 1));
    prev_acc = e.acc; prev_lat = e.lat;
    @(negedge clk);
    ifc.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while ((q.size() != 0 || !ifc.req_ready) && guard < 20) begin
      @(negedge clk); #1;
      guard++;
    end
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL resp_timeout: %0d responses outstanding, required 0", q.size());
      q.delete();
    end
  endtask

  // Scoreboard: every resp_valid cycle must match the oldest expected response.
  always @(negedge clk) begin
    exp_t e;
    if (ifc.resp_valid) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_resp: resp_valid=1, required 0 (cycle %0d)", cyc);
      end else begin
        e = q.pop_front();
        check32("resp_rdata", ifc.resp_rdata, e.rd);
        check32("resp_err", {31'b0, ifc.resp_err}, {31'b0, e.err});
        check32("resp_latency", 32'(cyc - e.acc), 32'(e.lat));
        last_rdata = ifc.resp_rdata;
        last_err   = ifc.resp_err;
      end
    end
  end

  initial begin
    logic [31:0] w;
    for (int i = 0; i < 64; i++) begin
      w = init_word(i);
      for (int k = 0; k < 4; k++) mm[4*i + k] = w[8*k +: 8];
    end
    ifc.req_valid = 1'b0; ifc.req_we = 1'b0; ifc.req_size = 2'b00; ifc.req_signed = 1'b0;
    ifc.req_addr = '0; ifc.req_wdata = '0;
    mem_load = 1'b1;
    repeat (3) @(negedge clk);
    mem_load = 1'b0;
    #1;
    check32("rst_req_ready", {31'b0, ifc.req_ready}, 32'd1);
    check32("rst_resp_valid", {31'b0, ifc.resp_valid}, 32'd0);
    check32("rst_resp_rdata", ifc.resp_rdata, 32'd0);
    check32("rst_resp_err", {31'b0, ifc.resp_err}, 32'd0);
    check32("rst_mem_en", {31'b0, ifc.mem_en}, 32'd0);
    check32("rst_mem_we", {31'b0, ifc.mem_we}, 32'd0);
    check32("rst_mem_addr", {2'b0, ifc.mem_addr}, 32'd0);
    check32("rst_mem_wdata", ifc.mem_wdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // lb signed from the top lane of 0x80FF_7F01.
    do_req(1'b0, SIZE_BYTE, 1'b1, 32'h0000_0013, 32'h0, 1'b1, 1'b0);
    check32("lb_mem_addr", {2'b0, obs_addr}, 32'd4);
    wait_idle();
    check32("lb_signed_data", last_rdata, 32'hFFFF_FF80);

    do_req(1'b0, SIZE_HALF, 1'b0, 32'h0000_0012, 32'h0, 1'b1, 1'b0);
    wait_idle();
    check32("lhu_data", last_rdata, 32'h0000_80FF);
    repeat (3) @(negedge clk);
    check32("rdata_hold", ifc.resp_rdata, 32'h0000_80FF);

    // Store 0x1122_3344, then merge one byte into lane 1.
    do_req(1'b1, SIZE_WORD, 1'b0, 32'h0000_0010, 32'h1122_3344, 1'b1, 1'b0);
    wait_idle();
    do_req(1'b1, SIZE_BYTE, 1'b0, 32'h0000_0011, 32'h0000_00AB, 1'b1, 1'b0);
    check32("sb_read_not_write", {31'b0, obs_we}, 32'd0);
    wait_idle();
    check32("sb_merged_word", tbmem[4], 32'h1122_AB44);
    check32("store_resp_rdata", last_rdata, 32'd0);

    // sw followed by a load held on req_valid through the response cycle.
    do_req(1'b1, SIZE_WORD, 1'b0, 32'h0000_0020, 32'hDEAD_BEEF, 1'b1, 1'b0);
    check32("sw_mem_addr", {2'b0, obs_addr}, 32'd8);
    check32("sw_mem_wdata", obs_wdata, 32'hDEAD_BEEF);
    do_req(1'b0, SIZE_WORD, 1'b0, 32'h0000_0020, 32'h0, 1'b1, 1'b1);
    wait_idle();
    check32("lw_after_sw", last_rdata, 32'hDEAD_BEEF);

    // Misaligned lw.
    do_req(1'b0, SIZE_WORD, 1'b0, 32'h0000_0006, 32'h0, 1'b1, 1'b0);
    wait_idle();
    if (TRAP) begin
      check32("lw_mis_no_access", {31'b0, obs_en}, 32'd0);
      check32("lw_mis_err", {31'b0, last_err}, 32'd1);
    end else begin
      check32("lw_mis_addr", {2'b0, obs_addr}, 32'd1);
      check32("lw_mis_data", last_rdata, init_word(1));
    end

    // sh interrupted by reset while waiting for read data.
    do_req(1'b1, SIZE_HALF, 1'b0, 32'h0000_0022, 32'h0000_1234, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    check32("rst_rwait_mem_en", {31'b0, ifc.mem_en}, 32'd0);
    @(negedge clk); #1;
    check32("rst2_req_ready", {31'b0, ifc.req_ready}, 32'd1);
    check32("rst2_resp_valid", {31'b0, ifc.resp_valid}, 32'd0);
    check32("rst2_mem_en", {31'b0, ifc.mem_en}, 32'd0);
    check32("rst2_mem_addr", {2'b0, ifc.mem_addr}, 32'd0);
    check32("rst2_mem_wdata", ifc.mem_wdata, 32'd0);
    check32("rst2_resp_rdata", ifc.resp_rdata, 32'd0);
    reset = 1'b0;
    q.delete();
    @(negedge clk);
    check32("sh_aborted_word", tbmem[8], 32'hDEAD_BEEF);

    // Randomized back-to-back traffic.
    for (int i = 0; i < 200; i++) begin
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             $urandom, $urandom, 1'b1, i > 0);
    end
    wait_idle();

    for (int i = 0; i < 64; i++) begin
      w = {mm[4*i + 3], mm[4*i + 2], mm[4*i + 1], mm[4*i]};
      check32($sformatf("mem_word_%0d", i), tbmem[i], w);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
